// File: rtl/voice_allocator_if.sv
// Voice allocator bus: decoded MIDI events in, per-voice write records and status out.
interface voice_allocator_if #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VOICE_W    = 3
);
  logic                  note_pressed;
  logic                  note_released;
  logic [6:0]            note;
  logic [6:0]            velocity;
  logic [3:0]            channel;
  logic                  voice_we;
  logic [VOICE_W-1:0]    voice_idx;
  logic [6:0]            voice_note;
  logic [6:0]            voice_vel;
  logic                  voice_gate;
  logic                  steal;
  logic                  overflow;
  logic                  busy;
  logic [NUM_VOICES-1:0] active_mask;

  modport master (
    output note_pressed, note_released, note, velocity, channel,
    input  voice_we, voice_idx, voice_note, voice_vel, voice_gate,
    input  steal, overflow, busy, active_mask
  );

  modport slave (
    input  note_pressed, note_released, note, velocity, channel,
    output voice_we, voice_idx, voice_note, voice_vel, voice_gate,
    output steal, overflow, busy, active_mask
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: retrigger, lowest free voice, or steal the least recently
// pressed voice; one voice examined per cycle, one pending event buffered while busy.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VOICE_W    = 3
) (
  input logic              clk,
  input logic              rst_n,
  voice_allocator_if.slave bus
);

  localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  typedef struct packed {
    logic       press;
    logic [6:0] note;
    logic [6:0] vel;
    logic [3:0] chan;
  } event_t;

  state_t                state;
  state_t                state_nx;
  event_t                cur;
  event_t                pend;
  logic                  pend_valid;
  logic [VOICE_W-1:0]    scan_idx;
  logic                  hit_found;
  logic                  free_found;
  logic [VOICE_W-1:0]    hit_idx;
  logic [VOICE_W-1:0]    free_idx;
  logic [VOICE_W-1:0]    old_idx;
  logic [NUM_VOICES-1:0] gate;
  logic [6:0]            note_tab [NUM_VOICES];
  logic [3:0]            chan_tab [NUM_VOICES];
  logic [VOICE_W-1:0]    age      [NUM_VOICES];

  event_t             ev_first;
  event_t             ev_rel;
  logic               have_first;
  logic               have_second;
  logic               cur_match;
  logic               hit_found_nx;
  logic               free_found_nx;
  logic [VOICE_W-1:0] hit_idx_nx;
  logic [VOICE_W-1:0] free_idx_nx;
  logic [VOICE_W-1:0] old_idx_nx;
  logic [VOICE_W-1:0] sel_idx;
  logic               sel_steal;
  logic               scan_last;
  logic               do_write;
  logic               can_start;
  logic               load_cur;
  event_t             cur_src;
  logic               pend_load;
  event_t             pend_src;
  logic               drop;

  assign bus.active_mask = gate;

  // Incoming events: a zero-velocity press is a release; press is ordered before release.
  always_comb begin
    ev_rel      = '{press: 1'b0, note: bus.note, vel: bus.velocity, chan: bus.channel};
    ev_first    = ev_rel;
    have_first  = bus.note_pressed | bus.note_released;
    have_second = bus.note_pressed & bus.note_released;
    if (bus.note_pressed) begin
      ev_first.press = (bus.velocity != 7'd0);
    end
  end

  // One-voice-per-cycle search, merged with the candidates found so far.
  always_comb begin
    cur_match     = gate[scan_idx] && (note_tab[scan_idx] == cur.note) &&
                    (chan_tab[scan_idx] == cur.chan);
    hit_found_nx  = hit_found | cur_match;
    hit_idx_nx    = hit_found ? hit_idx : scan_idx;
    free_found_nx = free_found | ~gate[scan_idx];
    free_idx_nx   = free_found ? free_idx : scan_idx;
    old_idx_nx    = (age[scan_idx] == LAST_IDX) ? scan_idx : old_idx;
    sel_idx       = hit_found_nx ? hit_idx_nx : (free_found_nx ? free_idx_nx : old_idx_nx);
    sel_steal     = cur.press && !hit_found_nx && !free_found_nx;
    scan_last     = (state == SCAN) && (scan_idx == LAST_IDX);
    do_write      = scan_last && (cur.press || hit_found_nx);
    can_start     = (state == IDLE) || (state == WRITE) || (scan_last && !do_write);
  end

  // Route events to the current and pending slots; anything left over is dropped.
  always_comb begin
    load_cur  = can_start && (pend_valid || have_first);
    cur_src   = pend_valid ? pend : ev_first;
    pend_load = 1'b0;
    pend_src  = ev_first;
    drop      = 1'b0;
    if (can_start) begin
      if (pend_valid) begin
        pend_load = have_first;
        drop      = have_second;
      end else begin
        pend_load = have_second;
        pend_src  = ev_rel;
      end
    end else if (!pend_valid) begin
      pend_load = have_first;
      drop      = have_second;
    end else begin
      drop = have_first;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_cur) state_nx = SCAN;
      SCAN:    if (scan_last) state_nx = do_write ? WRITE : (load_cur ? SCAN : IDLE);
      WRITE:   state_nx = load_cur ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur            <= '0;
      pend           <= '0;
      pend_valid     <= 1'b0;
      scan_idx       <= '0;
      hit_found      <= 1'b0;
      free_found     <= 1'b0;
      hit_idx        <= '0;
      free_idx       <= '0;
      old_idx        <= '0;
      gate           <= '0;
      bus.voice_we   <= 1'b0;
      bus.voice_idx  <= '0;
      bus.voice_note <= '0;
      bus.voice_vel  <= '0;
      bus.voice_gate <= 1'b0;
      bus.steal      <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.busy       <= 1'b0;
      for (int j = 0; j < NUM_VOICES; j++) begin
        note_tab[j] <= '0;
        chan_tab[j] <= '0;
        age[j]      <= VOICE_W'(j);
      end
    end else begin
      state        <= state_nx;
      bus.busy     <= (state_nx != IDLE);
      bus.overflow <= drop;

      if (load_cur) begin
        cur        <= cur_src;
        scan_idx   <= '0;
        hit_found  <= 1'b0;
        free_found <= 1'b0;
        hit_idx    <= '0;
        free_idx   <= '0;
        old_idx    <= '0;
      end else if (state == SCAN) begin
        scan_idx   <= scan_idx + VOICE_W'(1);
        hit_found  <= hit_found_nx;
        free_found <= free_found_nx;
        hit_idx    <= hit_idx_nx;
        free_idx   <= free_idx_nx;
        old_idx    <= old_idx_nx;
      end

      if (pend_load) begin
        pend       <= pend_src;
        pend_valid <= 1'b1;
      end else if (can_start) begin
        pend_valid <= 1'b0;
      end

      // Write record is a one-cycle pulse; idx/note/vel keep their last value.
      bus.voice_we   <= 1'b0;
      bus.voice_gate <= 1'b0;
      bus.steal      <= 1'b0;
      if (do_write) begin
        bus.voice_we   <= 1'b1;
        bus.voice_idx  <= sel_idx;
        bus.voice_note <= cur.press ? cur.note : note_tab[sel_idx];
        bus.voice_vel  <= cur.vel;
        bus.voice_gate <= cur.press;
        bus.steal      <= sel_steal;
      end

      // Voice tables commit as the WRITE cycle ends; presses also refresh LRU ranks.
      if (state == WRITE) begin
        gate[bus.voice_idx] <= cur.press;
        if (cur.press) begin
          note_tab[bus.voice_idx] <= cur.note;
          chan_tab[bus.voice_idx] <= cur.chan;
          for (int j = 0; j < NUM_VOICES; j++) begin
            if (VOICE_W'(j) == bus.voice_idx) begin
              age[j] <= '0;
            end else if (age[j] < age[bus.voice_idx]) begin
              age[j] <= age[j] + VOICE_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed vector bench for voice_allocator: table of single events plus hand-built
// multi-event sequences (pending/overflow, mid-scan reset, simultaneous press+release).
module tb_voice_allocator;
  localparam int unsigned NV = 8;
  localparam int unsigned VW = 3;

  typedef struct {
    bit       rst;
    bit       press;
    bit       rel;
    bit [6:0] note;
    bit [6:0] vel;
    bit [3:0] ch;
    bit       exp_we;
    bit [2:0] exp_idx;
    bit       exp_gate;
    bit       exp_steal;
    bit [6:0] exp_note;
    bit [6:0] exp_vel;
    bit [7:0] exp_mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(NV), .VOICE_W(VW)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .VOICE_W(VW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input bit p, input bit r, input int note, input int vel, input int ch);
    bus.note_pressed  = p;
    bus.note_released = r;
    bus.note          = 7'(note);
    bus.velocity      = 7'(vel);
    bus.channel       = 4'(ch);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(bit rst, bit p, bit r, int note, int vel, int ch, bit we,
                              int idx, bit g, bit s, int enote, int evel, int mask);
    vec_t v;
    v.rst = rst; v.press = p; v.rel = r;
    v.note = 7'(note); v.vel = 7'(vel); v.ch = 4'(ch);
    v.exp_we = we; v.exp_idx = 3'(idx); v.exp_gate = g; v.exp_steal = s;
    v.exp_note = 7'(enote); v.exp_vel = 7'(evel); v.exp_mask = 8'(mask);
    return v;
  endfunction

  // One event from IDLE; records the write (if any), latency and final mask.
  task automatic apply(input vec_t v, input string tag);
    int cyc, lat, got, done;
    int w_idx, w_gate, w_steal, w_note, w_vel;
    if (v.rst) do_reset();
    @(posedge clk); #1;
    drive(v.press, v.rel, v.note, v.vel, v.ch);
    @(posedge clk); #1;
    drive(0, 0, v.note, v.vel, v.ch);
    cyc = 1; got = 0; done = 0; lat = 0;
    w_idx = 0; w_gate = 0; w_steal = 0; w_note = 0; w_vel = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.voice_we) begin
        got = 1; lat = cyc;
        w_idx = bus.voice_idx; w_gate = bus.voice_gate; w_steal = bus.steal;
        w_note = bus.voice_note; w_vel = bus.voice_vel;
      end
      if (!bus.busy) begin
        done = 1;
        break;
      end
      cyc++;
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".we"}, got, v.exp_we);
    if (v.exp_we) begin
      check({tag, ".latency"}, lat, NV + 1);
      check({tag, ".idx"}, w_idx, v.exp_idx);
      check({tag, ".gate"}, w_gate, v.exp_gate);
      check({tag, ".steal"}, w_steal, v.exp_steal);
      check({tag, ".note"}, w_note, v.exp_note);
      check({tag, ".vel"}, w_vel, v.exp_vel);
      check({tag, ".note_hold"}, bus.voice_note, v.exp_note);
      check({tag, ".gate_after"}, bus.voice_gate, 0);
      check({tag, ".steal_after"}, bus.steal, 0);
    end
    check({tag, ".mask"}, bus.active_mask, v.exp_mask);
  endtask

  initial begin
    int wcnt, ocnt;
    int w_idx[4], w_note[4], w_gate[4];
    drive(0, 0, 0, 0, 0);

    // reset state
    do_reset();
    @(negedge clk);
    check("reset.busy", bus.busy, 0);
    check("reset.mask", bus.active_mask, 0);
    check("reset.we", bus.voice_we, 0);
    check("reset.idx", bus.voice_idx, 0);
    check("reset.overflow", bus.overflow, 0);

    // single press
    vecs.push_back(mk(1, 1, 0, 60, 100, 0, 1, 0, 1, 0, 60, 100, 'h01));
    // free search and release
    vecs.push_back(mk(1, 1, 0, 60, 100, 0, 1, 0, 1, 0, 60, 100, 'h01));
    vecs.push_back(mk(0, 1, 0, 62, 101, 0, 1, 1, 1, 0, 62, 101, 'h03));
    vecs.push_back(mk(0, 1, 0, 64, 102, 0, 1, 2, 1, 0, 64, 102, 'h07));
    vecs.push_back(mk(0, 0, 1, 62, 40, 0, 1, 1, 0, 0, 62, 40, 'h05));
    vecs.push_back(mk(0, 1, 0, 67, 90, 0, 1, 1, 1, 0, 67, 90, 'h07));
    // fill all voices, then steal oldest twice
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(k == 0, 1, 0, 40 + k, 50 + k, 0, 1, k, 1, 0, 40 + k, 50 + k,
                        (1 << (k + 1)) - 1));
    vecs.push_back(mk(0, 1, 0, 48, 58, 0, 1, 0, 1, 1, 48, 58, 'hff));
    vecs.push_back(mk(0, 1, 0, 49, 59, 0, 1, 1, 1, 1, 49, 59, 'hff));
    // retrigger, channel separation, zero-velocity release, unmatched releases
    vecs.push_back(mk(1, 1, 0, 60, 100, 0, 1, 0, 1, 0, 60, 100, 'h01));
    vecs.push_back(mk(0, 1, 0, 60, 110, 0, 1, 0, 1, 0, 60, 110, 'h01));
    vecs.push_back(mk(0, 1, 0, 60, 70, 1, 1, 1, 1, 0, 60, 70, 'h03));
    vecs.push_back(mk(0, 1, 0, 60, 0, 0, 1, 0, 0, 0, 60, 0, 'h02));
    vecs.push_back(mk(0, 0, 1, 99, 10, 0, 0, 0, 0, 0, 0, 0, 'h02));
    vecs.push_back(mk(0, 0, 1, 60, 10, 2, 0, 0, 0, 0, 0, 0, 'h02));
    vecs.push_back(mk(0, 0, 1, 60, 33, 1, 1, 1, 0, 0, 60, 33, 'h00));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // three strobes two cycles apart: two serviced in order, third overflows
    do_reset();
    wcnt = 0; ocnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (c == 0)      drive(1, 0, 60, 100, 0);
      else if (c == 2) drive(1, 0, 62, 100, 0);
      else if (c == 4) drive(1, 0, 64, 100, 0);
      else             drive(0, 0, 0, 0, 0);
      @(negedge clk);
      if (bus.voice_we && wcnt < 4) begin
        w_idx[wcnt] = bus.voice_idx; w_note[wcnt] = bus.voice_note; w_gate[wcnt] = bus.voice_gate;
      end
      if (bus.voice_we) wcnt++;
      if (bus.overflow) ocnt++;
    end
    check("pend.writes", wcnt, 2);
    check("pend.w0_idx", w_idx[0], 0);
    check("pend.w0_note", w_note[0], 60);
    check("pend.w1_idx", w_idx[1], 1);
    check("pend.w1_note", w_note[1], 62);
    check("pend.overflow", ocnt, 1);
    check("pend.mask", bus.active_mask, 'h03);
    check("pend.busy", bus.busy, 0);

    // reset during scan with pending valid: nothing is written afterwards
    apply(mk(1, 1, 0, 50, 80, 0, 1, 0, 1, 0, 50, 80, 'h01), "pre0");
    apply(mk(0, 1, 0, 52, 81, 0, 1, 1, 1, 0, 52, 81, 'h03), "pre1");
    wcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 0)      drive(1, 0, 64, 100, 0);
      else if (c == 2) drive(1, 0, 66, 100, 0);
      else             drive(0, 0, 0, 0, 0);
      if (c == 5) rst_n = 1'b0;
      if (c == 6) rst_n = 1'b1;
      @(negedge clk);
      if (bus.voice_we) wcnt++;
    end
    check("midrst.writes", wcnt, 0);
    check("midrst.busy", bus.busy, 0);
    check("midrst.mask", bus.active_mask, 0);
    apply(mk(0, 1, 0, 70, 90, 0, 1, 0, 1, 0, 70, 90, 'h01), "midrst.next");

    // press and release on the same cycle: retrigger then release voice 0
    wcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 0) drive(1, 1, 70, 95, 0);
      else        drive(0, 0, 0, 0, 0);
      @(negedge clk);
      if (bus.voice_we && wcnt < 4) begin
        w_idx[wcnt] = bus.voice_idx; w_note[wcnt] = bus.voice_note; w_gate[wcnt] = bus.voice_gate;
      end
      if (bus.voice_we) wcnt++;
    end
    check("both.writes", wcnt, 2);
    check("both.w0_idx", w_idx[0], 0);
    check("both.w0_gate", w_gate[0], 1);
    check("both.w1_idx", w_idx[1], 0);
    check("both.w1_gate", w_gate[1], 0);
    check("both.w1_note", w_note[1], 70);
    check("both.mask", bus.active_mask, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
